// File: rtl/gmii_rx_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ==== gmii_rx_pkg : state encoding, framing constants and RX_ERR bit indices for the GMII receive checker ====
// ==== Revision 1.0                                                                                        ====
package gmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_PRE   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DROP  = 2'd3
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD         = 8'hD5;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  localparam int ERR_CRC  = 0;
  localparam int ERR_GMII = 1;
  localparam int ERR_LEN  = 2;

endpackage
`default_nettype wire

// File: rtl/eth_crc32_d8.sv
`default_nettype none
`timescale 1ns/1ps
// ==== eth_crc32_d8 : combinational byte-wide CRC-32 step, reflected polynomial, bit 0 first ====
// ==== Revision 1.0                                                                           ====
module eth_crc32_d8
  import gmii_rx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_c;

  always_comb begin
    w_c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (w_c[0] ^ data[i]) w_c = (w_c >> 1) ^ CRC_POLY;
      else                  w_c = w_c >> 1;
    end
  end

  assign crc_out = w_c;

endmodule
`default_nettype wire

// File: rtl/gmii_rx_frame_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ==== gmii_rx_frame_checker : GMII receive preamble/SFD/FCS stripper with frame verdict and statistics ====
// ==== Revision 1.0                                                                                    ====
module gmii_rx_frame_checker
  import gmii_rx_pkg::*;
#(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int CNT_W   = 16
) (
  input  logic             GMII_CLK,
  input  logic             RESET_N,
  input  logic             GMII_RX_DV,
  input  logic [7:0]       GMII_RXD,
  input  logic             GMII_RX_ER,
  input  logic             CNT_CLR,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  output logic             RX_SOF,
  output logic             RX_EOF,
  output logic             RX_GOOD,
  output logic [2:0]       RX_ERR,
  output logic [CNT_W-1:0] GOOD_CNT,
  output logic [CNT_W-1:0] BAD_CNT,
  output logic [CNT_W-1:0] DROP_CNT
);

  // Byte-count thresholds include the 4 FCS bytes still in the delay line.
  localparam logic [10:0]      c_min_cnt = 11'(MIN_LEN + 4);
  localparam logic [10:0]      c_max_cnt = 11'(MAX_LEN + 4);
  localparam logic [10:0]      c_fill    = 11'd5;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  rx_state_t   r_state, w_state_next;
  logic        r_dv_prev;
  logic [2:0]  r_pre_cnt;
  logic [10:0] r_byte_cnt;
  logic [7:0]  r_dly [5];
  logic [31:0] r_crc, w_crc_next;
  logic        r_gmii_err;
  logic        w_rise, w_pre_inc, w_shift, w_emit, w_end, w_drop;
  logic        w_good_inc, w_bad_inc;
  logic [2:0]  w_err;

  eth_crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (GMII_RXD),
    .crc_out (w_crc_next)
  );

  assign w_rise = GMII_RX_DV & ~r_dv_prev;

  always_ff @(posedge GMII_CLK) begin
    if (!RESET_N) r_state <= ST_ARMED;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pre_inc    = 1'b0;
    w_shift      = 1'b0;
    w_emit       = 1'b0;
    w_end        = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_ARMED, ST_PRE: begin
        if (r_state == ST_PRE && !GMII_RX_DV) begin
          w_drop       = 1'b1;
          w_state_next = ST_ARMED;
        end else if (r_state == ST_PRE || w_rise) begin
          // The rising-edge byte is already part of the preamble check.
          if (GMII_RXD == PREAMBLE && r_pre_cnt != 3'd7) begin
            w_pre_inc    = 1'b1;
            w_state_next = ST_PRE;
          end else if (GMII_RXD == SFD) begin
            w_state_next = ST_DATA;
          end else begin
            w_drop       = 1'b1;
            w_state_next = ST_DROP;
          end
        end
      end
      ST_DATA: begin
        if (GMII_RX_DV) begin
          w_shift = 1'b1;
          w_emit  = (r_byte_cnt >= c_fill);
        end else begin
          w_end        = 1'b1;
          w_state_next = ST_ARMED;
          if (r_byte_cnt >= c_fill) w_emit = 1'b1;
          else                      w_drop = 1'b1;
        end
      end
      ST_DROP: begin
        if (!GMII_RX_DV) w_state_next = ST_ARMED;
      end
      default: w_state_next = ST_ARMED;
    endcase
  end

  always_comb begin
    w_err           = 3'b000;
    w_err[ERR_LEN]  = (r_byte_cnt < c_min_cnt) || (r_byte_cnt > c_max_cnt);
    w_err[ERR_GMII] = r_gmii_err;
    w_err[ERR_CRC]  = (r_crc != CRC_RESIDUE);
  end

  assign w_good_inc = w_emit & w_end & (w_err == 3'b000);
  assign w_bad_inc  = w_emit & w_end & (w_err != 3'b000);

  always_ff @(posedge GMII_CLK) begin
    if (!RESET_N) begin
      r_dv_prev  <= 1'b1;
      r_pre_cnt  <= 3'd0;
      r_byte_cnt <= 11'd0;
      r_crc      <= CRC_INIT;
      r_gmii_err <= 1'b0;
      for (int i = 0; i < 5; i++) r_dly[i] <= 8'h00;
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      RX_SOF     <= 1'b0;
      RX_EOF     <= 1'b0;
      RX_GOOD    <= 1'b0;
      RX_ERR     <= 3'b000;
    end else begin
      r_dv_prev <= GMII_RX_DV;
      r_pre_cnt <= w_pre_inc ? r_pre_cnt + 3'd1 : 3'd0;
      if (w_end) begin
        r_byte_cnt <= 11'd0;
        r_crc      <= CRC_INIT;
        r_gmii_err <= 1'b0;
        for (int i = 0; i < 5; i++) r_dly[i] <= 8'h00;
      end else if (w_shift) begin
        r_dly[0] <= GMII_RXD;
        for (int i = 1; i < 5; i++) r_dly[i] <= r_dly[i-1];
        r_crc      <= w_crc_next;
        r_byte_cnt <= (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
        r_gmii_err <= r_gmii_err | GMII_RX_ER;
      end
      RX_VALID <= w_emit;
      RX_DATA  <= w_emit ? r_dly[4] : 8'h00;
      RX_SOF   <= w_emit && (r_byte_cnt == c_fill);
      RX_EOF   <= w_emit && w_end;
      RX_GOOD  <= w_good_inc;
      RX_ERR   <= (w_emit && w_end) ? w_err : 3'b000;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != '1) ? v + c_cnt_one : v;
  endfunction

  always_ff @(posedge GMII_CLK) begin
    if (!RESET_N || CNT_CLR) begin
      GOOD_CNT <= '0;
      BAD_CNT  <= '0;
      DROP_CNT <= '0;
    end else begin
      GOOD_CNT <= sat_inc(GOOD_CNT, w_good_inc);
      BAD_CNT  <= sat_inc(BAD_CNT, w_bad_inc);
      DROP_CNT <= sat_inc(DROP_CNT, w_drop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_frame_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ==== tb_gmii_rx_frame_checker : directed + randomized frames against a frame-level reference model ====
// ==== Revision 1.0                                                                                   ====
module tb_gmii_rx_frame_checker;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             dv = 1'b0;
  logic [7:0]       rxd = 8'h00;
  logic             er = 1'b0;
  logic             clr = 1'b0;
  logic [7:0]       RX_DATA;
  logic             RX_VALID, RX_SOF, RX_EOF, RX_GOOD;
  logic [2:0]       RX_ERR;
  logic [CNT_W-1:0] GOOD_CNT, BAD_CNT, DROP_CNT;

  gmii_rx_frame_checker #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .GMII_CLK   (clk),
    .RESET_N    (rst_n),
    .GMII_RX_DV (dv),
    .GMII_RXD   (rxd),
    .GMII_RX_ER (er),
    .CNT_CLR    (clr),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .RX_SOF     (RX_SOF),
    .RX_EOF     (RX_EOF),
    .RX_GOOD    (RX_GOOD),
    .RX_ERR     (RX_ERR),
    .GOOD_CNT   (GOOD_CNT),
    .BAD_CNT    (BAD_CNT),
    .DROP_CNT   (DROP_CNT)
  );

  always #4 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        good;
    logic [2:0]  err;
  } beat_t;

  int    cyc = 0;
  int    spurious = 0;
  int    errors = 0;
  int    checks = 0;
  int    m_good = 0, m_bad = 0, m_drop = 0;
  beat_t exp_q[$];
  beat_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    beat_t b;
    if (RX_VALID) begin
      b.cyc  = cyc;
      b.data = RX_DATA;
      b.sof  = RX_SOF;
      b.eof  = RX_EOF;
      b.good = RX_GOOD;
      b.err  = RX_ERR;
      got_q.push_back(b);
    end else if (RX_SOF || RX_EOF || RX_GOOD || RX_ERR != 3'b000) begin
      spurious <= spurious + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Standard Ethernet FCS: complemented reflected CRC-32 over the payload.
  function automatic logic [31:0] fcs_of(input bq_t q, input int from, input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, q[from + i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t mk_frame(input int pre, input int n, input bit seq, input bit bad);
    bq_t q;
    logic [31:0] f;
    for (int i = 0; i < pre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    for (int i = 0; i < n; i++) q.push_back(seq ? 8'(i) : 8'($urandom));
    f = fcs_of(q, pre + 1, n);
    q.push_back(f[7:0] ^ (bad ? 8'h01 : 8'h00));
    q.push_back(f[15:8]);
    q.push_back(f[23:16]);
    q.push_back(f[31:24]);
    return q;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic c);
    @(negedge clk);
    dv = v; rxd = d; er = e; clr = c;
  endtask

  // Drives a DV-high burst and records the outcome the framing rules predict.
  task automatic send(input bq_t stream, input int er_idx, input int gap, input bit clr_end);
    int    s, cnt55, m, n;
    bit    ok, fcs_ok;
    int    cy[$];
    logic [31:0] f;
    logic [2:0]  e;
    beat_t b;
    s = -1; cnt55 = 0; ok = 0;
    for (int i = 0; i < stream.size(); i++) begin
      if (stream[i] == 8'hD5) begin ok = 1; s = i; break; end
      else if (stream[i] == 8'h55 && cnt55 < 7) cnt55++;
      else break;
    end
    for (int i = 0; i < stream.size(); i++) begin
      drive(1'b1, stream[i], i == er_idx, 1'b0);
      cy.push_back(cyc);
    end
    for (int g = 0; g < gap; g++) drive(1'b0, 8'h00, 1'b0, (g == 0) && clr_end);
    m = ok ? stream.size() - s - 1 : 0;
    if (!ok || m < 5) begin
      m_drop++;
    end else begin
      n = m - 4;
      f = fcs_of(stream, s + 1, n);
      fcs_ok = ({stream[s+n+4], stream[s+n+3], stream[s+n+2], stream[s+n+1]} == f);
      e = {(n < MIN_LEN) || (n > MAX_LEN), er_idx > s && er_idx < stream.size(), !fcs_ok};
      for (int j = 0; j < n; j++) begin
        b.cyc  = cy[s + 1 + j] + 6;
        b.data = stream[s + 1 + j];
        b.sof  = (j == 0);
        b.eof  = (j == n - 1);
        b.good = (j == n - 1) && (e == 3'b000);
        b.err  = (j == n - 1) ? e : 3'b000;
        exp_q.push_back(b);
      end
      if (e == 3'b000) m_good++;
      else             m_bad++;
    end
    if (clr_end) begin m_good = 0; m_bad = 0; m_drop = 0; end
  endtask

  task automatic settle_and_compare(input string tag);
    int k, nmin;
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk({tag, ".beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    k = 0;
    for (int i = 0; i < nmin; i++) begin
      if (got_q[i] !== exp_q[i]) begin k = i; break; end
    end
    if (nmin > 0) chk($sformatf("%s.beat%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    chk({tag, ".good_cnt"}, 64'(GOOD_CNT), 64'(m_good));
    chk({tag, ".bad_cnt"},  64'(BAD_CNT),  64'(m_bad));
    chk({tag, ".drop_cnt"}, 64'(DROP_CNT), 64'(m_drop));
    chk({tag, ".spurious"}, 64'(spurious), 64'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : main
    bq_t q;
    int  n, pre, er_idx;
    bit  bad;

    repeat (3) @(negedge clk);
    chk("reset_outputs",  64'({RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_GOOD, RX_ERR}), 64'd0);
    chk("reset_counters", 64'({GOOD_CNT, BAD_CNT, DROP_CNT}), 64'd0);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);

    q = mk_frame(7, 60, 1, 0);  send(q, -1, 1, 0); settle_and_compare("good60");
    q = mk_frame(7, 60, 1, 1);  send(q, -1, 1, 0); settle_and_compare("badfcs60");
    q = mk_frame(7, 59, 1, 0);  send(q, -1, 1, 0); settle_and_compare("short59");
    q = mk_frame(7, 60, 1, 0);  send(q, 28, 1, 0); settle_and_compare("rxer20");

    q = '{8'h55, 8'h55, 8'h12, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(q, -1, 1, 0); settle_and_compare("badpre");
    q = mk_frame(8, 60, 1, 0);  send(q, -1, 1, 0); settle_and_compare("pre8");
    q = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hA1, 8'hA2, 8'hA3};
    send(q, -1, 1, 0); settle_and_compare("runt3");
    q = '{8'h55, 8'h55, 8'hD5, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send(q, -1, 1, 0); settle_and_compare("runt4");
    q = mk_frame(0, 1, 0, 0);   send(q, -1, 1, 0); settle_and_compare("single");

    q = mk_frame(7, 64, 0, 0);  send(q, -1, 1, 0);
    q = mk_frame(7, 64, 0, 0);  send(q, -1, 1, 0); settle_and_compare("b2b");

    q = mk_frame(3, 1514, 0, 0); send(q, -1, 1, 0); settle_and_compare("max1514");
    q = mk_frame(3, 1515, 0, 0); send(q, -1, 1, 0); settle_and_compare("over1515");

    for (int f = 0; f < 12; f++) begin
      pre = $urandom_range(0, 7);
      n   = $urandom_range(1, 100);
      bad = ($urandom_range(0, 3) == 0);
      q   = mk_frame(pre, n, 0, bad);
      case ($urandom_range(0, 7))
        0, 1:    er_idx = pre + 1 + $urandom_range(0, n + 3);
        2:       er_idx = $urandom_range(0, pre);
        default: er_idx = -1;
      endcase
      send(q, er_idx, $urandom_range(1, 3), 0);
      settle_and_compare($sformatf("rand%0d", f));
    end

    q = mk_frame(7, 64, 1, 0);
    for (int i = 0; i < 30; i++) drive(1'b1, q[i], 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; rxd = q[30];
    @(negedge clk);
    chk("rst_mid_outputs",  64'({RX_DATA, RX_VALID, RX_SOF, RX_EOF, RX_GOOD, RX_ERR}), 64'd0);
    chk("rst_mid_counters", 64'({GOOD_CNT, BAD_CNT, DROP_CNT}), 64'd0);
    rxd = q[31];
    got_q.delete();
    m_good = 0; m_bad = 0; m_drop = 0;
    @(negedge clk); rst_n = 1'b1; rxd = q[32];
    for (int i = 33; i < q.size(); i++) drive(1'b1, q[i], 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    settle_and_compare("rst_mid_discard");
    q = mk_frame(7, 64, 0, 0);  send(q, -1, 1, 0); settle_and_compare("after_rst");

    q = mk_frame(7, 60, 0, 0);  send(q, -1, 2, 1); settle_and_compare("clr_at_eof");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
